// File: rtl/ro_buf_pkg.sv
// Shared definitions for the ring-oscillator sample buffer.
// Holds the FSM state encoding, the min-tracker initial value and default sizes.
package ro_buf_pkg;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_DW    = 32;

  localparam logic [DEF_DW-1:0] MIN_INIT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ro_buf_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read-before-write on address collision; no reset so it maps onto block RAM.
module ro_buf_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ro_sample_buffer.sv
// Captures ring-oscillator period measurements into a sample RAM, tracking
// fill level, overflow and running min/max; the first sample per enable is dropped.
//
// state | meaning
// IDLE  | capture disabled
// SKIP  | enabled, waiting to discard the partial first measurement
// RUN   | storing samples
// DONE  | RAM full with WRAP=0; further samples only set ovf
module ro_sample_buffer
  import ro_buf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 6,
  parameter int DW    = DEF_DW,
  parameter int WRAP  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cnt_in,
  input  logic          cnt_valid,
  input  logic          en,
  input  logic          clr,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          ovf,
  output logic [DW-1:0] min_cnt,
  output logic [DW-1:0] max_cnt,
  output logic [1:0]    state
);

  localparam logic [AW:0]   L_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_LAST     = L_DEPTH - 1'b1;
  localparam logic [DW-1:0] L_MIN_INIT = {DW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic          r_rd_valid;
  logic          r_rd_seen;
  logic          w_full;
  logic          w_hit;
  logic          w_we;
  logic [DW-1:0] w_ram_q;

  assign w_full = (r_count == L_DEPTH);
  assign w_hit  = cnt_valid && en && !clr;
  // A full buffer only accepts writes when overwriting is allowed.
  assign w_we   = (r_state == ST_RUN) && w_hit && (!w_full || (WRAP != 0));

  ro_buf_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (cnt_in),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_min      <= L_MIN_INIT;
      r_max      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_seen  <= r_rd_seen | rd_en;
      if (clr) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
        r_min    <= L_MIN_INIT;
        r_max    <= '0;
        r_state  <= en ? ST_SKIP : ST_IDLE;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (cnt_in < r_min) r_min <= cnt_in;
          if (cnt_in > r_max) r_max <= cnt_in;
        end
        case (r_state)
          ST_IDLE: if (en) r_state <= ST_SKIP;
          ST_SKIP: begin
            if (!en) r_state <= ST_IDLE;
            else if (cnt_valid) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (!en) begin
              r_state <= ST_IDLE;
            end else if (cnt_valid) begin
              // Full on entry is possible after re-enabling a filled buffer.
              if (w_full) begin
                r_ovf <= 1'b1;
                if (WRAP == 0) r_state <= ST_DONE;
              end else begin
                r_count <= r_count + 1'b1;
                if (r_count == L_LAST && WRAP == 0) r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (!en) r_state <= ST_IDLE;
            else if (cnt_valid) r_ovf <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // The RAM output register has no reset, so hide it until the first read.
  assign rd_data  = r_rd_seen ? w_ram_q : '0;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign full     = w_full;
  assign ovf      = r_ovf;
  assign min_cnt  = r_min;
  assign max_cnt  = r_max;
  assign state    = r_state;

endmodule

// File: tb/tb_ro_sample_buffer.sv
// Directed bench for ro_sample_buffer: a 64-deep stop-when-full instance plus
// 4-deep stop and wrap instances driven by the same stimulus.
module tb_ro_sample_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt_in;
  logic        cnt_valid;
  logic        en;
  logic        clr;
  logic        rd_en;
  logic [5:0]  rd_addr;

  logic [31:0] a_rd_data, b_rd_data, c_rd_data;
  logic        a_rd_valid, b_rd_valid, c_rd_valid;
  logic [6:0]  a_count;
  logic [2:0]  b_count, c_count;
  logic        a_full, b_full, c_full;
  logic        a_ovf, b_ovf, c_ovf;
  logic [31:0] a_min, b_min, c_min;
  logic [31:0] a_max, b_max, c_max;
  logic [1:0]  a_state, b_state, c_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ro_sample_buffer #(.DEPTH(64), .AW(6), .DW(32), .WRAP(0)) u_a (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .en(en), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .count(a_count), .full(a_full), .ovf(a_ovf), .min_cnt(a_min), .max_cnt(a_max),
    .state(a_state));

  ro_sample_buffer #(.DEPTH(4), .AW(2), .DW(32), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .en(en), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .count(b_count), .full(b_full), .ovf(b_ovf), .min_cnt(b_min), .max_cnt(b_max),
    .state(b_state));

  ro_sample_buffer #(.DEPTH(4), .AW(2), .DW(32), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .en(en), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
    .count(c_count), .full(c_full), .ovf(c_ovf), .min_cnt(c_min), .max_cnt(c_max),
    .state(c_state));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] v);
    @(posedge clk); #1;
    cnt_in    = v;
    cnt_valid = 1'b1;
    @(posedge clk); #1;
    cnt_valid = 1'b0;
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    en = v;
  endtask

  task automatic rd(input int a);
    @(posedge clk); #1;
    rd_en   = 1'b1;
    rd_addr = 6'(a);
    @(posedge clk); #1;
    rd_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt_in = '0; cnt_valid = 1'b0; en = 1'b0; clr = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    #12;
    chk("rst_state", 64'(a_state), 0);
    chk("rst_count", 64'(a_count), 0);
    chk("rst_full", 64'(a_full), 0);
    chk("rst_ovf", 64'(a_ovf), 0);
    chk("rst_rd_valid", 64'(a_rd_valid), 0);
    chk("rst_rd_data", 64'(a_rd_data), 0);
    chk("rst_min", 64'(a_min), 64'hFFFF_FFFF);
    chk("rst_max", 64'(a_max), 0);
    rst = 1'b0;

    // basic capture with first-sample drop
    set_en(1'b1);
    pulse(500);
    chk("t1_run_after_skip", 64'(a_state), 2);
    chk("t1_drop_count", 64'(a_count), 0);
    pulse(1000); pulse(1200); pulse(800);
    chk("t1_count", 64'(a_count), 3);
    chk("t1_min", 64'(a_min), 800);
    chk("t1_max", 64'(a_max), 1200);
    chk("t1_ovf", 64'(a_ovf), 0);
    rd(0); chk("t1_mem0", 64'(a_rd_data), 1000);
    rd(1); chk("t1_mem1", 64'(a_rd_data), 1200);
    rd(2); chk("t1_mem2", 64'(a_rd_data), 800);

    // clr coincident with cnt_valid
    @(posedge clk); #1;
    clr = 1'b1; cnt_valid = 1'b1; cnt_in = 77;
    @(posedge clk); #1;
    clr = 1'b0; cnt_valid = 1'b0;
    chk("t4_count", 64'(a_count), 0);
    chk("t4_min", 64'(a_min), 64'hFFFF_FFFF);
    chk("t4_max", 64'(a_max), 0);
    chk("t4_state", 64'(a_state), 1);
    pulse(99);
    chk("t4_drop_count", 64'(a_count), 0);
    for (int i = 1; i <= 6; i++) pulse(32'(i));
    chk("t4_a_count", 64'(a_count), 6);
    chk("t2_b_count", 64'(b_count), 4);
    chk("t2_b_full", 64'(b_full), 1);
    chk("t2_b_state", 64'(b_state), 3);
    chk("t2_b_ovf", 64'(b_ovf), 1);
    chk("t2_b_max", 64'(b_max), 4);
    chk("t3_c_count", 64'(c_count), 4);
    chk("t3_c_ovf", 64'(c_ovf), 1);
    chk("t3_c_state", 64'(c_state), 2);
    chk("t3_c_min", 64'(c_min), 1);
    chk("t3_c_max", 64'(c_max), 6);
    rd(0);
    chk("t4_a_slot0", 64'(a_rd_data), 1);
    chk("t2_b_mem0", 64'(b_rd_data), 1);
    chk("t3_c_mem0", 64'(c_rd_data), 5);
    rd(1);
    chk("t2_b_mem1", 64'(b_rd_data), 2);
    chk("t3_c_mem1", 64'(c_rd_data), 6);
    rd(2);
    chk("t2_b_mem2", 64'(b_rd_data), 3);
    chk("t3_c_mem2", 64'(c_rd_data), 3);
    rd(3);
    chk("t2_b_mem3", 64'(b_rd_data), 4);
    chk("t3_c_mem3", 64'(c_rd_data), 4);

    // disable / re-enable resumes at wr_ptr
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t5_idle", 64'(a_state), 0);
    set_en(1'b1);
    pulse(10); pulse(20); pulse(30);
    chk("t5_count2", 64'(a_count), 2);
    set_en(1'b0);
    @(posedge clk); #1;
    chk("t5_off_state", 64'(a_state), 0);
    chk("t5_off_count", 64'(a_count), 2);
    set_en(1'b1);
    pulse(40);
    chk("t5_reskip_count", 64'(a_count), 2);
    pulse(50);
    chk("t5_count3", 64'(a_count), 3);
    chk("t5_min", 64'(a_min), 20);
    chk("t5_max", 64'(a_max), 50);
    chk("t5_rd_valid_idle", 64'(a_rd_valid), 0);
    rd(2);
    chk("t5_rd_data", 64'(a_rd_data), 50);
    chk("t5_rd_valid", 64'(a_rd_valid), 1);
    @(posedge clk); #1;
    chk("t5_rd_valid_pulse", 64'(a_rd_valid), 0);

    // same-cycle write and read of slot 3 returns the old word
    @(posedge clk); #1;
    cnt_valid = 1'b1; cnt_in = 60; rd_en = 1'b1; rd_addr = 6'd3;
    @(posedge clk); #1;
    cnt_valid = 1'b0; rd_en = 1'b0;
    chk("rbw_old", 64'(a_rd_data), 4);
    chk("rbw_count", 64'(a_count), 4);
    rd(3);
    chk("rbw_new", 64'(a_rd_data), 60);

    // asynchronous reset between edges
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = 6'd0;
    @(posedge clk); #3;
    chk("t6_pre_rd_valid", 64'(a_rd_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_state", 64'(a_state), 0);
    chk("t6_count", 64'(a_count), 0);
    chk("t6_min", 64'(a_min), 64'hFFFF_FFFF);
    chk("t6_max", 64'(a_max), 0);
    chk("t6_rd_valid", 64'(a_rd_valid), 0);
    chk("t6_rd_data", 64'(a_rd_data), 0);
    chk("t6_b_ovf", 64'(b_ovf), 0);
    rd_en = 1'b0;
    #20;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_sample_buffer.md
# ro_sample_buffer

Downstream of the ring-oscillator period counter. Captures each completed measurement (`cnt_in` qualified by the single-cycle `cnt_valid` pulse) into an on-chip sample RAM. Tracks running min/max and fill status, and exposes a synchronous read port for the CPU bus bridge. The first measurement after each enable is discarded because its window is partial.

## Interface
Parameters:
- `DEPTH`, 64: sample slots; must be a power of two, ≥ 4.
- `AW`, 6: address width, equal to log2(DEPTH).
- `DW`, 32: sample width; matches the counter output.
- `WRAP`, 0: 0 stops capture when the RAM is full; 1 overwrites the oldest sample.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `cnt_in` in DW: measured clock count; stable whenever `cnt_valid` is high.
- `cnt_valid` in 1: one-cycle pulse marking a new measurement.
- `en` in 1: capture enable (level).
- `clr` in 1: synchronous clear of pointer, count, flags and min/max; RAM contents are not cleared.
- `rd_en` in 1: read request.
- `rd_addr` in AW: read slot index.
- `rd_data` out DW: registered read data.
- `rd_valid` out 1: high one cycle after `rd_en`.
- `count` out AW+1: stored samples; saturates at DEPTH.
- `full` out 1: `count == DEPTH`.
- `ovf` out 1: sticky; a sample arrived while full.
- `min_cnt` out DW: smallest stored sample.
- `max_cnt` out DW: largest stored sample.
- `state` out 2: current FSM state, for debug.

## Operation
FSM states: IDLE=0, SKIP=1, RUN=2, DONE=3.
- **IDLE**
  - `en`=1 → SKIP.
- **SKIP**
  - `cnt_valid` → RUN; the sample is dropped.
  - `en`=0 → IDLE.
- **RUN**
  - On `cnt_valid`: `mem[wr_ptr] <= cnt_in`; `wr_ptr` increments mod DEPTH; `count` increments.
  - Min/max update: `min_cnt <= min(min_cnt, cnt_in)`, `max_cnt <= max(max_cnt, cnt_in)`.
  - On the write that makes `count` reach DEPTH: → DONE if WRAP=0; stay in RUN if WRAP=1.
  - WRAP=1 with `full`=1: the write still occurs (overwrite), `count` holds at DEPTH, and `ovf` is set.
  - `en`=0 → IDLE.
- **DONE** (WRAP=0 only)
  - `cnt_valid` → no write; set `ovf`.
  - `en`=0 → IDLE.
- Any state, `clr`=1:
  - `wr_ptr`, `count` and `ovf` → 0.
  - `min_cnt` → all ones; `max_cnt` → 0.
  - Next state is SKIP if `en`=1, otherwise IDLE.
  - `clr` has priority over a coincident `cnt_valid`; that sample is dropped.
- Leaving RUN/DONE via `en`=0 keeps RAM, count and min/max. Re-enabling goes through SKIP and appends at `wr_ptr`.
- Reads are independent of the FSM: `rd_data <= mem[rd_addr]`. Addresses beyond `count` return stale data and are not flagged.
- Arithmetic: comparisons are unsigned DW-bit; `wr_ptr` wraps naturally at AW bits; `count` is AW+1 bits and never exceeds DEPTH.

## Timing
- Reset values:
  - state IDLE; `wr_ptr`=0, `count`=0.
  - `full`, `ovf`, `rd_valid` = 0; `rd_data`=0.
  - `min_cnt` = all ones, `max_cnt` = 0.
- Capture: `cnt_valid` sampled at edge N. `count`, `full`, `min_cnt`/`max_cnt` and the RAM word are updated and visible after edge N; a read issued at N+1 returns the new word at N+2.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data`/`rd_valid` after edge N; `rd_valid` is a one-cycle pulse per request; back-to-back reads are allowed every cycle.
- Same-cycle write and read of one address returns the old word (read-before-write).
- `cnt_valid` pulses are at least 2 cycles apart upstream; the block still handles consecutive-cycle pulses correctly.
- `rst` asserted mid-operation returns all state to reset values immediately. RAM contents are undefined afterwards.

## Structure
- Package `ro_buf_pkg`:
  - state encoding constants (IDLE/SKIP/RUN/DONE);
  - `MIN_INIT` (all ones);
  - default DEPTH/DW.
- Sub-module `ro_buf_ram`: simple dual-port RAM with one write port and one synchronous-read port, read-before-write, no reset; it should infer block RAM.
- Top level holds the FSM, pointers, count/flags and min/max registers.

## Test plan
1. Reset, `en`=1, pulses with values 500, 1000, 1200, 800 → first dropped; mem[0..2] = 1000, 1200, 800; `count`=3; `min_cnt`=800; `max_cnt`=1200; `ovf`=0.
2. WRAP=0, DEPTH=4, six post-skip pulses → `count`=4, `full`=1, state DONE, `ovf`=1; mem holds the first four samples only.
3. WRAP=1, DEPTH=4, samples 1..6 → mem = {5, 6, 3, 4}, `count`=4, `ovf`=1.
4. `clr` coincident with `cnt_valid` while `en`=1 → `count`=0, `min_cnt`=FFFF_FFFF, state SKIP; the next pulse is dropped and the following one is stored at slot 0.
5. `en` dropped after 2 samples, then re-raised → the first pulse after re-enable is dropped, the next is stored at slot 2; `rd_en` with `rd_addr`=2 gives the value and `rd_valid` one cycle later.
6. `rst` asserted asynchronously mid-RUN between clock edges → outputs return to reset values without waiting for a clock edge.
